// File: rtl/core_ma_lsu_read_data_merge_if.sv
// Load command descriptor, Avalon read-data return and writeback result
// bundle for the memory-access stage read-data merge unit.
interface core_ma_lsu_read_data_merge_if;
    logic        cmd_push;
    logic [1:0]  cmd_addr_lo;
    logic [2:0]  cmd_data_len;
    logic [2:0]  cmd_op_type;
    logic        cmd_full;
    logic [31:0] avl_m0_read_data;
    logic        avl_m0_read_data_valid;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_err;
    logic        unexp_beat;
    logic        busy;

    modport master (
        output cmd_push, cmd_addr_lo, cmd_data_len, cmd_op_type,
        output avl_m0_read_data, avl_m0_read_data_valid,
        input  cmd_full, load_data, load_valid, misalign_err,
        input  unexp_beat, busy
    );

    modport slave (
        input  cmd_push, cmd_addr_lo, cmd_data_len, cmd_op_type,
        input  avl_m0_read_data, avl_m0_read_data_valid,
        output cmd_full, load_data, load_valid, misalign_err,
        output unexp_beat, busy
    );
endinterface

// File: rtl/core_ma_lsu_read_data_merge.sv
// LSU read-data merge: in-order descriptor FIFO, beat merge, load extension.
// CORE_LSU_MISALIGN_EN enables two-beat merging of word-crossing loads.
module core_ma_lsu_read_data_merge #(
    parameter int PEND_DEPTH = 2
) (
    input logic clk,
    input logic rest,
    core_ma_lsu_read_data_merge_if.slave bus
);
    localparam int AW = $clog2(PEND_DEPTH);

    typedef struct packed {
        logic [1:0] addr_lo;
        logic [2:0] len;
        logic [2:0] op;
        logic       two_word;
    } desc_t;

`ifdef CORE_LSU_MISALIGN_EN
    typedef enum logic [1:0] {EMPTY, WAIT_FIRST, WAIT_SECOND} state_t;
`else
    typedef enum logic [1:0] {EMPTY, WAIT_FIRST} state_t;
`endif

    function automatic logic crosses(input logic [1:0] a, input logic [2:0] l);
        return ({2'b00, a} + {1'b0, l}) > 4'd4;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [2:0] len,
                                           input logic zext);
        case (len)
            3'd1:    return zext ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            3'd2:    return zext ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_t      state, state_n;
    desc_t       mem [PEND_DEPTH];
    desc_t       head, new_desc;
    logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic        full, push_ok, pop, complete, unexp;
    logic [31:0] hi_word, lo_sel;
    logic [63:0] shifted;
    logic [31:0] result;
    logic        unused_bits;
`ifdef CORE_LSU_MISALIGN_EN
    logic [31:0] lo_word;
    logic        capture_lo;
`endif

    assign head = mem[rd_ptr[AW-1:0]];
    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot for a push while full
    assign push_ok = bus.cmd_push && (!full || pop);

    always_comb begin
        new_desc         = '0;
        new_desc.addr_lo = bus.cmd_addr_lo;
        new_desc.len     = bus.cmd_data_len;
        new_desc.op      = bus.cmd_op_type;
`ifdef CORE_LSU_MISALIGN_EN
        new_desc.two_word = crosses(bus.cmd_addr_lo, bus.cmd_data_len);
`endif
    end

    always_comb begin
        pop      = 1'b0;
        complete = 1'b0;
        unexp    = 1'b0;
        hi_word  = '0;
        lo_sel   = bus.avl_m0_read_data;
`ifdef CORE_LSU_MISALIGN_EN
        capture_lo = 1'b0;
`endif
        unique case (state)
            EMPTY: unexp = bus.avl_m0_read_data_valid;
            WAIT_FIRST: begin
                if (bus.avl_m0_read_data_valid) begin
`ifdef CORE_LSU_MISALIGN_EN
                    if (head.two_word) begin
                        capture_lo = 1'b1;
                    end else begin
                        complete = 1'b1;
                        pop      = 1'b1;
                    end
`else
                    complete = 1'b1;
                    pop      = 1'b1;
`endif
                end
            end
`ifdef CORE_LSU_MISALIGN_EN
            WAIT_SECOND: begin
                if (bus.avl_m0_read_data_valid) begin
                    complete = 1'b1;
                    pop      = 1'b1;
                    hi_word  = bus.avl_m0_read_data;
                    lo_sel   = lo_word;
                end
            end
`endif
            default: ;
        endcase
    end

    assign wr_n = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_n = rd_ptr + {{AW{1'b0}}, pop};

    always_comb begin
        state_n = state;
        if (state == EMPTY) begin
            if (push_ok) state_n = WAIT_FIRST;
`ifdef CORE_LSU_MISALIGN_EN
        end else if (capture_lo) begin
            state_n = WAIT_SECOND;
`endif
        end else if (pop) begin
            state_n = (wr_n == rd_n) ? EMPTY : WAIT_FIRST;
        end
    end

    assign shifted = {hi_word, lo_sel} >> {head.addr_lo, 3'b000};
    assign result  = extend(shifted[31:0], head.len, head.op[2]);

`ifdef CORE_LSU_MISALIGN_EN
    assign unused_bits = ^head.op[1:0];
`else
    assign unused_bits = ^{head.op[1:0], head.two_word};
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= new_desc;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state            <= EMPTY;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.load_data    <= '0;
            bus.load_valid   <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.unexp_beat   <= 1'b0;
`ifdef CORE_LSU_MISALIGN_EN
            lo_word          <= '0;
`endif
        end else begin
            state          <= state_n;
            wr_ptr         <= wr_n;
            rd_ptr         <= rd_n;
            bus.load_valid <= complete;
            bus.unexp_beat <= unexp;
            if (complete) bus.load_data <= result;
`ifdef CORE_LSU_MISALIGN_EN
            bus.misalign_err <= 1'b0;
            if (capture_lo) lo_word <= bus.avl_m0_read_data;
`else
            bus.misalign_err <= complete && crosses(head.addr_lo, head.len);
`endif
        end
    end

    assign bus.cmd_full = full;
    assign bus.busy     = (state != EMPTY);
endmodule

// File: tb/tb_core_ma_lsu_read_data_merge.sv
// Directed self-checking bench for core_ma_lsu_read_data_merge.
// Expected values follow the build's CORE_LSU_MISALIGN_EN setting.
module tb_core_ma_lsu_read_data_merge;
    logic clk = 1'b0;
    logic rest = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    core_ma_lsu_read_data_merge_if bus ();

    core_ma_lsu_read_data_merge #(.PEND_DEPTH(2)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] a, input logic [2:0] l,
                           input logic [2:0] o);
        bus.cmd_push     = 1'b1;
        bus.cmd_addr_lo  = a;
        bus.cmd_data_len = l;
        bus.cmd_op_type  = o;
    endtask

    task automatic push(input logic [1:0] a, input logic [2:0] l,
                        input logic [2:0] o);
        set_cmd(a, l, o);
        tick();
        bus.cmd_push = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        bus.avl_m0_read_data       = d;
        bus.avl_m0_read_data_valid = 1'b1;
        tick();
        bus.avl_m0_read_data_valid = 1'b0;
    endtask

    task automatic push_beat(input logic [1:0] a, input logic [2:0] l,
                             input logic [2:0] o, input logic [31:0] d);
        set_cmd(a, l, o);
        bus.avl_m0_read_data       = d;
        bus.avl_m0_read_data_valid = 1'b1;
        tick();
        bus.cmd_push               = 1'b0;
        bus.avl_m0_read_data_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v,
                             input logic [31:0] d, input logic m);
        check({tag, "_valid"}, {31'b0, bus.load_valid}, {31'b0, v});
        if (v) check({tag, "_data"}, bus.load_data, d);
        check({tag, "_mis"}, {31'b0, bus.misalign_err}, {31'b0, m});
    endtask

    initial begin
        bus.cmd_push               = 1'b0;
        bus.cmd_addr_lo            = '0;
        bus.cmd_data_len           = '0;
        bus.cmd_op_type            = '0;
        bus.avl_m0_read_data       = '0;
        bus.avl_m0_read_data_valid = 1'b0;
        tick();
        tick();
        check("rst_data", bus.load_data, 32'h0);
        check("rst_valid", {31'b0, bus.load_valid}, 32'h0);
        check("rst_mis", {31'b0, bus.misalign_err}, 32'h0);
        check("rst_unexp", {31'b0, bus.unexp_beat}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_full", {31'b0, bus.cmd_full}, 32'h0);
        rest = 1'b0;
        tick();

        // Aligned LW
        push(2'd0, 3'd4, 3'b010);
        check("lw_busy", {31'b0, bus.busy}, 32'h1);
        beat(32'h8899AABB);
        check_out("lw", 1'b1, 32'h8899AABB, 1'b0);
        check("lw_idle", {31'b0, bus.busy}, 32'h0);
        tick();
        check("lw_pulse", {31'b0, bus.load_valid}, 32'h0);

        // LB / LBU at byte 3
        push(2'd3, 3'd1, 3'b000);
        beat(32'h80112233);
        check_out("lb", 1'b1, 32'hFFFFFF80, 1'b0);
        push(2'd3, 3'd1, 3'b100);
        beat(32'h80112233);
        check_out("lbu", 1'b1, 32'h00000080, 1'b0);

        // Word-crossing LW at addr_lo=2
        push(2'd2, 3'd4, 3'b010);
        beat(32'h44332211);
`ifdef CORE_LSU_MISALIGN_EN
        check("lw2_wait", {31'b0, bus.load_valid}, 32'h0);
        check("lw2_busy", {31'b0, bus.busy}, 32'h1);
        beat(32'h88776655);
        check_out("lw2", 1'b1, 32'h66554433, 1'b0);
`else
        check_out("lw2", 1'b1, 32'h00004433, 1'b1);
`endif

        // Word-crossing LH at addr_lo=3
        push(2'd3, 3'd2, 3'b001);
        beat(32'hAA000000);
`ifdef CORE_LSU_MISALIGN_EN
        beat(32'h000000FF);
        check_out("lh3", 1'b1, 32'hFFFFFFAA, 1'b0);
`else
        check_out("lh3", 1'b1, 32'h000000AA, 1'b1);
`endif

        // Full FIFO, dropped push, push+pop while full
        push(2'd0, 3'd4, 3'b010);
        push(2'd1, 3'd1, 3'b100);
        check("full_set", {31'b0, bus.cmd_full}, 32'h1);
        push(2'd0, 3'd1, 3'b000);
        check("full_drop", {31'b0, bus.cmd_full}, 32'h1);
        push_beat(2'd2, 3'd2, 3'b101, 32'h11223344);
        check_out("fa", 1'b1, 32'h11223344, 1'b0);
        check("full_keep", {31'b0, bus.cmd_full}, 32'h1);
        beat(32'h0000AB00);
        check_out("fb", 1'b1, 32'h000000AB, 1'b0);
        check("full_clr", {31'b0, bus.cmd_full}, 32'h0);
        beat(32'hBEEF0000);
        check_out("fc", 1'b1, 32'h0000BEEF, 1'b0);
        check("fc_idle", {31'b0, bus.busy}, 32'h0);

        // Beat with nothing pending
        beat(32'h12345678);
        check("ue_flag", {31'b0, bus.unexp_beat}, 32'h1);
        check("ue_valid", {31'b0, bus.load_valid}, 32'h0);

        // Beat in the same cycle as the first push is unexpected
        push_beat(2'd0, 3'd4, 3'b010, 32'hDEADBEEF);
        check("sc_unexp", {31'b0, bus.unexp_beat}, 32'h1);
        check("sc_valid", {31'b0, bus.load_valid}, 32'h0);
        check("sc_busy", {31'b0, bus.busy}, 32'h1);
        beat(32'hCAFEF00D);
        check_out("sc", 1'b1, 32'hCAFEF00D, 1'b0);
        check("sc_noue", {31'b0, bus.unexp_beat}, 32'h0);

        // Reset with a load in flight
        push(2'd2, 3'd4, 3'b010);
        beat(32'h44332211);
        rest = 1'b1;
        #1;
        check("mr_data", bus.load_data, 32'h0);
        check("mr_valid", {31'b0, bus.load_valid}, 32'h0);
        check("mr_mis", {31'b0, bus.misalign_err}, 32'h0);
        check("mr_busy", {31'b0, bus.busy}, 32'h0);
        check("mr_full", {31'b0, bus.cmd_full}, 32'h0);
        tick();
        rest = 1'b0;
        tick();
        beat(32'h88776655);
        check("mr_unexp", {31'b0, bus.unexp_beat}, 32'h1);
        check("mr_novalid", {31'b0, bus.load_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
